add_32_serial: RTL and testbench
================================

Name: add_32_serial

Overview:
- Multi-cycle signed adder, the additive counterpart to the 2-bit-slice subtractor in the GCD datapath.
- Processes operands 2 bits per clock through one 2-bit full-adder slice, with the carry held in a register between cycles.
- Used wherever the GCD/LCM control needs addition with low area. Start/done handshake.
- Produces the WIDTH-bit sum and a signed-overflow flag.

Parameters:
- WIDTH, 32, operand/result width; must be even and at least 4.
- SLICE, 2, bits processed per cycle; fixed at 2, elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  signed operand, captured on the accepted start edge.
- B  input  WIDTH  signed operand, captured on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when op/ovf are updated.
- op  output  WIDTH  signed sum A+B mod 2^WIDTH; holds its value until the next completion.
- ovf  output  1  signed overflow of the last completed addition.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, busy=0, done=0, op=0, ovf=0, carry=0, slice count=0.
- Reset mid-RUN aborts the operation: no done pulse, op/ovf cleared.
- States and transitions:
  - IDLE: start=1 at edge E0 latches A and B into a_q and b_q, clears carry and cnt, goes to RUN, busy=1.
  - RUN: each edge adds slice bits [2*cnt+1 : 2*cnt] of a_q and b_q plus carry. The 2-bit sum goes into shadow register s_q at the same position; carry takes the slice carry-out; cnt increments.
  - RUN, final slice (cnt=WIDTH/2-1, edge E16 for WIDTH=32): op takes the completed s_q, ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), done=1, busy=0, state returns to IDLE.
- Latency: start at E0, done high in the cycle after E(WIDTH/2). A new start is accepted in the same cycle that done is high, giving a throughput of one result per WIDTH/2+1 cycles.
- Ports and operand registers:
  - start during RUN is ignored; a_q and b_q never change mid-operation.
  - A and B are don't-care except at the accepted start edge.
  - op, ovf and done change only at completion or reset; no partial sums are ever visible on op.
- Arithmetic: two's complement. Carry out of bit WIDTH-1 is discarded, so unsigned wrap-around is normal. Overflow is reported on ovf only.
- done is high for exactly one cycle and is cleared on the following edge.

Optional Feature:
- Macro: ADD_SERIAL_SAT_EN.
- Defined: when ovf=1 at completion, op saturates to the signed limit.
  - Both operands positive: 0x7FFFFFFF.
  - Both operands negative: 0x80000000.
  - The sign of a_q selects which limit applies.
  - ovf still reports the overflow.
- Undefined: op is the wrapped sum; no saturation logic is present.

Test Plan:
- Reset, then A=478, B=219, start one cycle -> busy=1 for 16 cycles, done pulse on the 17th cycle after start, op=697, ovf=0.
- A=-209, B=104 -> op=-105 (0xFFFFFF97), ovf=0.
- A=-4, B=5 -> op=1. Then A=9, B=68 with start asserted during the done cycle -> accepted, op=77 after a further 17 cycles.
- A=0x7FFFFFFF, B=1 -> ovf=1. op=0x80000000 without ADD_SERIAL_SAT_EN, op=0x7FFFFFFF with it.
- Both edge cases:
  - A=0x80000000, B=0xFFFFFFFF -> ovf=1, op=0x7FFFFFFF (wrapped) or 0x80000000 (saturated).
  - A=-1, B=1 -> op=0, ovf=0 (carry out discarded).
- Start pulsed at cycles 3 and 9 of RUN with changed A/B -> ignored, result matches original operands. rst_n=0 at cycle 8 of a later run -> no done, op=0, ovf=0, busy=0 next cycle.

Source files
------------

// File: rtl/add_32_serial.sv
// ---------------------------------------------------------------------------
// add_32_serial
//   Multi-cycle signed adder with low area. It adds two bits per clock
//   through a single 2-bit full-adder slice and keeps the carry in a
//   register between cycles. A request is accepted on start while IDLE.
//   The result appears on op/ovf together with a one-cycle done pulse.
//
// Parameters:
//   WIDTH  operand/result width; must be even and at least 4
//   SLICE  bits processed per cycle; must be 2
//
// Optional feature:
//   ADD_SERIAL_SAT_EN  when defined, an overflowing result saturates to the
//                      signed limit selected by the sign of operand A.
//                      ovf still reports the overflow.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   request; sampled only while IDLE
//   A, B   in   signed operands, captured on the accepted start edge
//   busy   out  high while an addition is running
//   done   out  one-cycle pulse when op/ovf are updated
//   op     out  A+B mod 2^WIDTH (or the saturated value); held until the
//               next completion
//   ovf    out  signed overflow of the last completed addition
// ---------------------------------------------------------------------------
module add_32_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] op,
  output logic             ovf
);

  generate
    if (SLICE != 2) begin : g_bad_slice
      $error("add_32_serial: SLICE must be 2");
    end
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("add_32_serial: WIDTH must be even and at least 4");
    end
  endgenerate

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = $clog2(NSL);
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Bit offset of the current slice: 2*cnt.
  logic [CW:0]      idx;
  logic [1:0]       a_sl, b_sl;
  logic             c_mid, c_out;
  logic [1:0]       sum_sl;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH-1:0] res;

  assign idx  = {cnt, 1'b0};
  assign a_sl = a_q[idx +: SLICE];
  assign b_sl = b_q[idx +: SLICE];

  // 2-bit ripple slice. On the final slice, c_mid is the carry into bit
  // WIDTH-1 and c_out is the carry out of it, so their XOR is signed overflow.
  assign c_mid     = (a_sl[0] & b_sl[0]) | (carry & (a_sl[0] ^ b_sl[0]));
  assign c_out     = (a_sl[1] & b_sl[1]) | (c_mid & (a_sl[1] ^ b_sl[1]));
  assign sum_sl[0] = a_sl[0] ^ b_sl[0] ^ carry;
  assign sum_sl[1] = a_sl[1] ^ b_sl[1] ^ c_mid;

  // Shadow sum with the current slice merged in. On the last slice this is
  // the complete result, so op can load it in the same edge.
  always_comb begin
    s_next                = s_q;
    s_next[idx +: SLICE]  = sum_sl;
  end

`ifdef ADD_SERIAL_SAT_EN
  // Overflow only happens when both operands share a sign, so a_q's sign
  // selects the limit.
  always_comb begin
    res = s_next;
    if (c_mid ^ c_out) begin
      res = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                         : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign res = s_next;
`endif

  // NOTE: all state is updated with non-blocking assignments. Every register
  // then sees the pre-edge values of the others, whatever order the
  // statements are written in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      op    <= '0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          s_q   <= s_next;
          carry <= c_out;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            op    <= res;
            ovf   <= c_mid ^ c_out;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_32_serial.sv
// ---------------------------------------------------------------------------
// tb_add_32_serial
//   Directed self-checking bench for add_32_serial (WIDTH=32). Inputs change
//   and outputs are sampled on the falling clock edge. Expected results are
//   hand-computed constants. Saturated values apply when ADD_SERIAL_SAT_EN
//   is defined.
// ---------------------------------------------------------------------------
module tb_add_32_serial;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A, B;
  logic        busy, done, ovf;
  logic [31:0] op;

  int checks = 0;
  int errors = 0;

  add_32_serial #(.WIDTH(32), .SLICE(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .op    (op),
    .ovf   (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request at the current falling edge. It is sampled on the next
  // rising edge (E0).
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
  endtask

  // Step falling edges until done or until a 40-cycle bound expires. start
  // drops after E0 unless a cycle index appears in p1/p2. Those cycles pulse
  // start with changed operands, which the DUT must ignore. The task returns
  // at the falling edge on which done is high.
  task automatic wait_done(input string tag, input logic [31:0] exp_op,
                           input logic exp_ovf, input int p1, input int p2);
    int cycles = 0;
    int busy_n = 0;
    bit seen   = 1'b0;
    while (!seen && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (busy) busy_n++;
      if (done) seen = 1'b1;
      else begin
        start = (cycles == p1) || (cycles == p2);
        if (start) begin
          A = 32'hFFFF_FFFF;
          B = 32'hFFFF_FFFF;
        end
      end
    end
    check({tag, "_latency"}, 32'(cycles), 32'd17);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd16);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_op"}, op, exp_op);
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
  endtask

  initial begin
    int done_n;
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_op", op, 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 478 + 219 = 697
    start_op(32'd478, 32'd219);
    wait_done("pos_add", 32'd697, 1'b0, -1, -1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("op_hold", op, 32'd697);

    // -209 + 104 = -105
    start_op(-32'sd209, 32'd104);
    wait_done("neg_add", 32'hFFFF_FF97, 1'b0, -1, -1);
    @(negedge clk);

    // -4 + 5 = 1, then 9 + 68 = 77 requested during the done cycle
    start_op(-32'sd4, 32'd5);
    wait_done("mix_add", 32'd1, 1'b0, -1, -1);
    start_op(32'd9, 32'd68);
    wait_done("back2back", 32'd77, 1'b0, -1, -1);
    @(negedge clk);

    // Positive overflow
    start_op(32'h7FFF_FFFF, 32'd1);
`ifdef ADD_SERIAL_SAT_EN
    wait_done("pos_ovf", 32'h7FFF_FFFF, 1'b1, -1, -1);
`else
    wait_done("pos_ovf", 32'h8000_0000, 1'b1, -1, -1);
`endif
    @(negedge clk);

    // Negative overflow
    start_op(32'h8000_0000, 32'hFFFF_FFFF);
`ifdef ADD_SERIAL_SAT_EN
    wait_done("neg_ovf", 32'h8000_0000, 1'b1, -1, -1);
`else
    wait_done("neg_ovf", 32'h7FFF_FFFF, 1'b1, -1, -1);
`endif
    @(negedge clk);

    // -1 + 1 = 0; the carry out is discarded without overflow
    start_op(32'hFFFF_FFFF, 32'd1);
    wait_done("wrap_zero", 32'd0, 1'b0, -1, -1);
    @(negedge clk);

    // start pulsed at RUN cycles 3 and 9 with changed operands is ignored
    start_op(32'h1234_5678, 32'h0F0F_0F0F);
    wait_done("ignore_start", 32'h2143_6587, 1'b0, 3, 9);
    @(negedge clk);

    // Reset at cycle 8 of a run aborts it
    start_op(32'h1111_1111, 32'h2222_2222);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_op", op, 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    rst_n  = 1'b1;
    done_n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("abort_no_done", 32'(done_n), 32'd0);

    // Normal operation resumes after the abort: 100 + (-1) = 99
    start_op(32'd100, 32'hFFFF_FFFF);
    wait_done("after_abort", 32'd99, 1'b0, -1, -1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
